dev_axil_bridge: RTL and testbench
==================================

Name: dev_axil_bridge

Overview:
- Uncached device-access engine for the memory stage; serves every load/store whose address lies outside 0x8000_0000–0x87FF_FFFF, i.e. the non-cache path.
- Converts the stage's single-cycle request (ren/wen qualified by inst_update) into AXI4-Lite read and/or write transactions.
- Returns right-aligned 64-bit load data and a one-cycle finish pulse; sits directly downstream of the memory stage, which multiplexes its data and finish against the dcache path.

Parameters:
- ADDR_WIDTH, 64, request address width; bits [31:0] are forwarded to AXI.
- DATA_WIDTH, 64, data width; fixed at 64 in this revision.
- TIMEOUT_CYC, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- ren  input  1  load request
- wen  input  1  store request
- r_raddr  input  ADDR_WIDTH  load address
- r_waddr  input  ADDR_WIDTH  store address
- r_wdata  input  DATA_WIDTH  store data, already lane-aligned
- r_mask  input  8  store byte strobes
- inst_update  input  1  request-valid strobe
- r_rdata  output  DATA_WIDTH  load data, shifted right by raddr[2:0]*8
- finish  output  1  one-cycle completion pulse
- resp_err  output  1  sticky error for the last request; cleared on next accept
- araddr  output  32;  arvalid  output  1;  arready  input  1
- rdata  input  64;  rresp  input  2;  rvalid  input  1;  rready  output  1
- awaddr  output  32;  awvalid  output  1;  awready  input  1
- wdata  output  64;  wstrb  output  8;  wvalid  output  1;  wready  input  1
- bresp  input  2;  bvalid  input  1;  bready  output  1

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: all outputs 0; state IDLE.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Accept: in IDLE with inst_update & (ren|wen).
  - Latch both addresses, wdata, mask, ren and wen.
  - Clear resp_err.
  - Go to RD_ADDR if ren, else WR_REQ.
  - inst_update in any other state is ignored; the request is not queued.
- RD_ADDR:
  - arvalid=1, araddr=latched raddr[31:0].
  - On arready go to RD_DATA; arvalid then drops the next cycle.
- RD_DATA:
  - rready=1.
  - On rvalid: register r_rdata = rdata >> {raddr[2:0],3'b000}; resp_err |= (rresp!=0).
  - Next state is WR_REQ if the latched wen is set, else DONE.
- WR_REQ:
  - awvalid and wvalid asserted together; each drops independently after its own handshake.
  - Both handshakes may complete in the same cycle or in either order.
  - Leave only when both are done; go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid: resp_err |= (bresp!=0); go to DONE.
- DONE: finish=1 for exactly one cycle, then IDLE.
- Latency: with zero-wait slaves, a read finishes 3 cycles after accept and a write finishes 3 cycles after accept.
- ren & wen together: read first, then write; a single finish at the end.
- Data hold: r_rdata holds its value until the next read completes; a write-only request leaves it unchanged.
- AXI rule: valid is never deasserted before its ready, and address/data are stable while valid is high.
- Reset mid-transaction: immediate return to IDLE with all valid/ready outputs low and no finish.

Optional Feature:
- Macro: DEV_AXIL_TIMEOUT_EN.
- When defined:
  - A counter runs in every non-IDLE, non-DONE state and clears on each state change.
  - When it reaches TIMEOUT_CYC: force DONE, set resp_err=1, r_rdata=0, drop all valid/ready outputs.
  - Intended for simulation, to catch a hung device.
- When undefined: no counter; the bridge waits indefinitely.

Decomposition:
- Shared package (mem_pkg) holds:
  - the state enum;
  - the AXI resp constants OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11;
  - the cacheable-window constants 0x8000_0000 and 0x87FF_FFFF.
- One natural sub-module: dev_rd_align, a combinational lane shifter for the read data.

Test Plan:
- ld @0xA000_0048, slave returns rdata=0x1122334455667788 with zero wait -> arvalid 1 cycle, finish on cycle 3, r_rdata=0x1122334455667788, resp_err=0.
- lb @0xA000_03F9, rdata=0x0000_0000_0000_AB00 -> r_rdata[7:0]=0xAB.
- sd @0xA000_0000 with wdata=0xDEAD, mask=0xFF; awready delayed 2 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles, bready until bvalid, single finish pulse.
- ren=wen=1 -> AR/R complete before AW/W starts, exactly one finish; bresp=SLVERR -> resp_err=1.
- Reset asserted while in RD_DATA -> all outputs 0 on the same edge, no finish; the next request proceeds normally.
- With DEV_AXIL_TIMEOUT_EN and TIMEOUT_CYC=8, arready stuck at 0 -> finish 9 cycles after accept, resp_err=1, r_rdata=0.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-stage types: device bridge states, AXI responses, cacheable window
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } axil_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [31:0] CACHE_BASE  = 32'h8000_0000;
  localparam logic [31:0] CACHE_LIMIT = 32'h87FF_FFFF;

  // Anything outside this window is routed to the uncached device bridge.
  function automatic logic is_cacheable(input logic [31:0] addr);
    return (addr >= CACHE_BASE) && (addr <= CACHE_LIMIT);
  endfunction

endpackage

// File: rtl/dev_axil_bridge_if.sv
// rtl/dev_axil_bridge_if.sv - AXI4-Lite bus between the device bridge (master) and a device (slave)
interface dev_axil_bridge_if;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/dev_rd_align.sv
// rtl/dev_rd_align.sv - right-aligns a 64-bit read beat by the byte offset of the load address
module dev_rd_align #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [2:0]            offset,
  output logic [DATA_WIDTH-1:0] aligned
);

  assign aligned = data >> {offset, 3'b000};

endmodule

// File: rtl/dev_axil_bridge.sv
// rtl/dev_axil_bridge.sv - uncached load/store to AXI4-Lite bridge; optional watchdog via DEV_AXIL_TIMEOUT_EN
module dev_axil_bridge
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ren,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] r_raddr,
  input  logic [ADDR_WIDTH-1:0] r_waddr,
  input  logic [DATA_WIDTH-1:0] r_wdata,
  input  logic [7:0]            r_mask,
  input  logic                  inst_update,
  output logic [DATA_WIDTH-1:0] r_rdata,
  output logic                  finish,
  output logic                  resp_err,
  dev_axil_bridge_if.master     axi
);

  axil_state_e state_q, state_d;

  logic [31:0]           raddr_q;
  logic [31:0]           waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [7:0]            mask_q;
  logic                  ren_q;
  logic                  wen_q;
  logic                  aw_done_q;
  logic                  w_done_q;

  logic                  accept;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  rd_fire;
  logic                  b_fire;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] rd_aligned;

  // Only the low 32 address bits reach the device bus.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{r_raddr[ADDR_WIDTH-1:32], r_waddr[ADDR_WIDTH-1:32], ren_q};

  dev_rd_align #(.DATA_WIDTH(DATA_WIDTH)) u_rd_align (
    .data    (axi.rdata),
    .offset  (raddr_q[2:0]),
    .aligned (rd_aligned)
  );

  assign accept  = (state_q == IDLE) && inst_update && (ren || wen);
  assign aw_hs   = axi.awvalid && axi.awready;
  assign w_hs    = axi.wvalid && axi.wready;
  assign rd_fire = (state_q == RD_DATA) && axi.rvalid && !timeout;
  assign b_fire  = (state_q == WR_RESP) && axi.bvalid && !timeout;

`ifdef DEV_AXIL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] to_cnt_q;
  logic             busy;

  assign busy    = (state_q != IDLE) && (state_q != DONE);
  assign timeout = busy && (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (!busy || (state_d != state_q)) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_d     = state_q;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    finish      = 1'b0;
    axi.araddr  = raddr_q;
    axi.awaddr  = waddr_q;
    axi.wdata   = wdata_q;
    axi.wstrb   = mask_q;

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = ren ? RD_ADDR : WR_REQ;
      end
      RD_ADDR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        axi.rready = 1'b1;
        if (axi.rvalid) state_d = wen_q ? WR_REQ : DONE;
      end
      WR_REQ: begin
        // AW and W retire independently; the state moves on once both have.
        axi.awvalid = !aw_done_q;
        axi.wvalid  = !w_done_q;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      end
      WR_RESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_d = DONE;
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (timeout) state_d = DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      raddr_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      r_rdata   <= '0;
      resp_err  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        raddr_q  <= r_raddr[31:0];
        waddr_q  <= r_waddr[31:0];
        wdata_q  <= r_wdata;
        mask_q   <= r_mask;
        ren_q    <= ren;
        wen_q    <= wen;
        resp_err <= 1'b0;
      end

      if (state_q != WR_REQ) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end

      if (rd_fire) begin
        r_rdata <= rd_aligned;
        if (axi.rresp != OKAY) resp_err <= 1'b1;
      end

      if (b_fire && (axi.bresp != OKAY)) resp_err <= 1'b1;

      if (timeout) begin
        resp_err <= 1'b1;
        r_rdata  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dev_axil_bridge.sv
// tb/tb_dev_axil_bridge.sv - self-checking bench for dev_axil_bridge with a reactive AXI4-Lite slave
module tb_dev_axil_bridge;
  import mem_pkg::*;

  typedef struct {
    bit          ren;
    bit          wen;
    bit          noise;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic [63:0] slv_rdata;
    logic [1:0]  rresp;
    logic [1:0]  bresp;
    int          ar_dly;
    int          aw_dly;
    int          w_dly;
    logic [63:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_ar;
    int          exp_aw;
    int          exp_w;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren, wen, inst_update;
  logic [63:0] r_raddr, r_waddr, r_wdata;
  logic [7:0]  r_mask;
  logic [63:0] r_rdata;
  logic        finish, resp_err;

  dev_axil_bridge_if bus ();

  dev_axil_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .ren         (ren),
    .wen         (wen),
    .r_raddr     (r_raddr),
    .r_waddr     (r_waddr),
    .r_wdata     (r_wdata),
    .r_mask      (r_mask),
    .inst_update (inst_update),
    .r_rdata     (r_rdata),
    .finish      (finish),
    .resp_err    (resp_err),
    .axi         (bus.master)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  exp_t sb[$];
  vec_t vecs[9];

  int          cfg_ar_dly = 0, cfg_aw_dly = 0, cfg_w_dly = 0;
  logic [63:0] cfg_rdata  = '0;
  logic [1:0]  cfg_rresp  = OKAY, cfg_bresp = OKAY;
  bit          cfg_r_hold = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  // Device model: readies after a configurable number of valid cycles, R/B answer immediately.
  initial begin
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.rvalid = 1'b0; bus.bvalid = 1'b0;
    bus.rdata = '0; bus.rresp = OKAY; bus.bresp = OKAY;
    forever begin
      @(negedge clk);
      if (bus.arvalid) begin bus.arready = (ar_cnt >= cfg_ar_dly); ar_cnt++; end
      else begin bus.arready = 1'b0; ar_cnt = 0; end
      if (bus.awvalid) begin bus.awready = (aw_cnt >= cfg_aw_dly); aw_cnt++; end
      else begin bus.awready = 1'b0; aw_cnt = 0; end
      if (bus.wvalid) begin bus.wready = (w_cnt >= cfg_w_dly); w_cnt++; end
      else begin bus.wready = 1'b0; w_cnt = 0; end
      bus.rvalid = bus.rready && !cfg_r_hold;
      bus.rdata  = cfg_rdata;
      bus.rresp  = cfg_rresp;
      bus.bvalid = bus.bready;
      bus.bresp  = cfg_bresp;
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int   fin_cnt = 0, lat = 0, ar_n = 0, aw_n = 0, w_n = 0;
    bit   got_fin = 1'b0, rd_done = 1'b0, order_ok = 1'b1;
    exp_t e;
    string p;
    p = $sformatf("v%0d", idx);
    cfg_ar_dly = v.ar_dly; cfg_aw_dly = v.aw_dly; cfg_w_dly = v.w_dly;
    cfg_rdata = v.slv_rdata; cfg_rresp = v.rresp; cfg_bresp = v.bresp;

    @(negedge clk);
    inst_update = 1'b1; ren = v.ren; wen = v.wen;
    r_raddr = {32'h0, v.raddr}; r_waddr = {32'h0, v.waddr};
    r_wdata = v.wdata; r_mask = v.mask;
    sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    @(negedge clk);
    if (v.noise) begin
      ren = 1'b0; wen = 1'b1; r_waddr = 64'hA000_0FF0; r_wdata = 64'h5555;
    end else begin
      inst_update = 1'b0; ren = 1'b0; wen = 1'b0;
    end

    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) @(negedge clk);
      #2;
      if (bus.arvalid) begin
        ar_n++;
        if (bus.arready) check({p, "_araddr"}, {32'h0, bus.araddr}, {32'h0, v.raddr});
      end
      if (bus.rvalid && bus.rready) rd_done = 1'b1;
      if (bus.awvalid) begin
        aw_n++;
        if (bus.awready) check({p, "_awaddr"}, {32'h0, bus.awaddr}, {32'h0, v.waddr});
      end
      if (bus.wvalid) begin
        w_n++;
        if (bus.wready) begin
          check({p, "_wdata"}, bus.wdata, v.wdata);
          check({p, "_wstrb"}, {56'h0, bus.wstrb}, {56'h0, v.mask});
        end
      end
      if ((bus.awvalid || bus.wvalid) && v.ren && !rd_done) order_ok = 1'b0;
      if (finish) begin
        fin_cnt++;
        if (!got_fin) begin
          got_fin = 1'b1;
          lat = cyc;
          inst_update = 1'b0; wen = 1'b0;
          e = sb.pop_front();
          check({p, "_rdata"}, r_rdata, e.rdata);
          check({p, "_resp_err"}, {63'h0, resp_err}, {63'h0, e.err});
        end
      end
      if (got_fin && cyc >= lat + 3) break;
    end

    inst_update = 1'b0; ren = 1'b0; wen = 1'b0;
    if (!got_fin && sb.size() > 0) void'(sb.pop_front());
    check({p, "_finish_seen"}, {63'h0, got_fin}, 64'd1);
    check({p, "_latency"}, 64'(lat), 64'(v.exp_lat));
    check({p, "_finish_pulses"}, 64'(fin_cnt), 64'd1);
    check({p, "_ar_cycles"}, 64'(ar_n), 64'(v.exp_ar));
    check({p, "_aw_cycles"}, 64'(aw_n), 64'(v.exp_aw));
    check({p, "_w_cycles"}, 64'(w_n), 64'(v.exp_w));
    if (v.ren && v.wen) check({p, "_read_before_write"}, {63'h0, order_ok}, 64'd1);
  endtask

  initial begin
    int fin_after_rst = 0;

    // ren wen noise raddr waddr wdata mask slv_rdata rresp bresp ar aw w | rdata err lat ar aw w
    vecs[0] = '{1, 0, 0, 32'hA000_0048, 32'h0, 64'h0, 8'h00, 64'h1122_3344_5566_7788, OKAY, OKAY, 0, 0, 0,
                64'h1122_3344_5566_7788, 0, 3, 1, 0, 0};
    vecs[1] = '{1, 0, 0, 32'hA000_03F9, 32'h0, 64'h0, 8'h00, 64'h0000_0000_0000_AB00, OKAY, OKAY, 0, 0, 0,
                64'h0000_0000_0000_00AB, 0, 3, 1, 0, 0};
    vecs[2] = '{0, 1, 0, 32'h0, 32'hA000_0000, 64'hDEAD, 8'hFF, 64'h0, OKAY, OKAY, 0, 2, 0,
                64'h0000_0000_0000_00AB, 0, 5, 0, 3, 1};
    vecs[3] = '{1, 1, 0, 32'hA000_0010, 32'hA000_0018, 64'h1234_5678, 8'h0F, 64'hCAFE_BABE_0000_1234, OKAY, SLVERR, 0, 0, 0,
                64'hCAFE_BABE_0000_1234, 1, 5, 1, 1, 1};
    vecs[4] = '{1, 0, 0, 32'hA000_0104, 32'h0, 64'h0, 8'h00, 64'h8877_6655_4433_2211, DECERR, OKAY, 0, 0, 0,
                64'h0000_0000_8877_6655, 1, 3, 1, 0, 0};
    vecs[5] = '{0, 1, 0, 32'h0, 32'hA000_0200, 64'hFF00_0000_0000_0000, 8'h80, 64'h0, OKAY, OKAY, 0, 0, 2,
                64'h0000_0000_8877_6655, 0, 5, 0, 1, 3};
    vecs[6] = '{1, 0, 1, 32'hA000_0007, 32'h0, 64'h0, 8'h00, 64'hEE00_0000_0000_0000, OKAY, OKAY, 3, 0, 0,
                64'h0000_0000_0000_00EE, 0, 6, 4, 0, 0};
    vecs[7] = '{0, 1, 0, 32'h0, 32'hA000_0300, 64'h0BAD_F00D, 8'h3C, 64'h0, OKAY, OKAY, 0, 1, 1,
                64'h0000_0000_0000_00EE, 0, 4, 0, 2, 2};
    vecs[8] = '{0, 1, 0, 32'h0, 32'hA000_0400, 64'h77, 8'h01, 64'h0, OKAY, OKAY, 0, 0, 0,
                64'h0, 0, 3, 0, 1, 1};

    rst = 1'b1; ren = 1'b0; wen = 1'b0; inst_update = 1'b0;
    r_raddr = '0; r_waddr = '0; r_wdata = '0; r_mask = '0;
    #2;
    check("reset_ctrl", {58'h0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, finish}, 64'h0);
    check("reset_rdata", r_rdata, 64'h0);
    check("reset_resp_err", {63'h0, resp_err}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset while waiting for read data: everything drops at once, nothing finishes.
    cfg_r_hold = 1'b1; cfg_ar_dly = 0;
    @(negedge clk);
    inst_update = 1'b1; ren = 1'b1; r_raddr = 64'hA000_0020;
    @(negedge clk);
    inst_update = 1'b0; ren = 1'b0;
    @(negedge clk);
    #2;
    check("mid_rd_data_rready", {63'h0, bus.rready}, 64'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_reset_ctrl", {58'h0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, finish}, 64'h0);
    check("mid_reset_rdata", r_rdata, 64'h0);
    check("mid_reset_resp_err", {63'h0, resp_err}, 64'h0);
    @(negedge clk);
    rst = 1'b0; cfg_r_hold = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #2;
      if (finish) fin_after_rst++;
    end
    check("no_finish_after_reset", 64'(fin_after_rst), 64'd0);

    run_vec(8, vecs[8]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
